// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity,
// 1 or 2 stop bits, each bit held for OVERSAMPLE baud ticks. Busy/done handshake.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_bit;
  logic                 bit_end;

  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (baud_tick && (state inside {S_START, S_DATA, S_PARITY, S_STOP}))
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

      // tx follows the current state, so the line lags each state change by one clk
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shreg      <= tx_data;
            parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
            tx_busy    <= 1'b1;
            state      <= S_SYNC;
          end
        end
        S_SYNC: begin
          tx <= 1'b1;
          if (baud_tick) begin
            tick_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          tx <= shreg[0];
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              state    <= S_AFTER_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          tx <= parity_bit;
          if (bit_end) begin
            stop_cnt <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              stop_cnt <= 1'b0;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              state    <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
